// File: rtl/ins_commit.sv
// ins_commit: commit/writeback stage behind the execute stage.
//
// Takes one execute result per exec_valid pulse while idle. If it carries a
// store, the store is issued on mem_w_req/mem_w_ack with a timeout. After that,
// a single writeback cycle applies the register-file write and the PC update,
// reports any fault and bumps the retired-instruction counter.
//
// Ports
//   sys_clk, sys_rst_n        clock (rising edge), synchronous active-low reset
//   exec_*                    execute-stage result, qualified by exec_valid
//   reg_pc_val                PC of the instruction being committed
//   busy                      high while in MEM or WB; upstream holds while set
//   rf_w_en/idx/val           register-file write port (one WB-cycle strobe)
//   mem_w_req/addr/val, ack   store handshake
//   pc_w_en/pc_w_val          PC write port (one WB-cycle strobe)
//   commit_done               one-cycle pulse per consumed instruction
//   commit_err/err_code       fault flag/code, only meaningful with commit_done
//                             (01 store timeout, 10 misaligned target)
//   instret                   64-bit retired-instruction counter
//
// Store handshake: mem_w_req rises on entry to MEM and stays high, with
// mem_w_addr/mem_w_val stable, until either an edge samples mem_w_ack=1 or
// the request has been high for MEM_ACK_TIMEOUT cycles. The store is
// accepted on the edge where req and ack are both high. If ack and timeout
// occur in the same cycle, the ack wins. mem_w_ack is ignored while req is low.
//
// Outputs are Moore: each is a function of the state register and the
// registered data only. The fault code and instret are resolved on the edge
// that enters WB. This makes them visible during the WB cycle itself.

module ins_commit #(
  parameter int MEM_ACK_TIMEOUT = 15
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        exec_valid,
  input  logic        exec_reg_w_op,
  input  logic [4:0]  exec_reg_w_reg_idx,
  input  logic [31:0] exec_reg_w_reg_val,
  input  logic        exec_mem_w_op,
  input  logic [31:0] exec_mem_w_mem_addr,
  input  logic [31:0] exec_mem_w_mem_val,
  input  logic        exec_reg_pc_w_op,
  input  logic [31:0] exec_reg_pc_w_val,
  input  logic [31:0] reg_pc_val,
  output logic        busy,
  output logic        rf_w_en,
  output logic [4:0]  rf_w_idx,
  output logic [31:0] rf_w_val,
  output logic        mem_w_req,
  output logic [31:0] mem_w_addr,
  output logic [31:0] mem_w_val,
  input  logic        mem_w_ack,
  output logic        pc_w_en,
  output logic [31:0] pc_w_val,
  output logic        commit_done,
  output logic        commit_err,
  output logic [1:0]  commit_err_code,
  output logic [63:0] instret
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ALIGN   = 2'b10;

  // Last counter value before the store is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(MEM_ACK_TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;

  // Latched execute result.
  logic        reg_w_op_q;
  logic [4:0]  reg_w_idx_q;
  logic [31:0] reg_w_val_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_val_q;
  logic        pc_op_q;
  logic [31:0] pc_tgt_q;
  logic [31:0] pc_q;

  logic [7:0]  tmo_cnt_q;
  logic [1:0]  err_code_q;
  logic [63:0] instret_q;

  // WB entry qualifiers, produced together with the next state.
  logic        enter_wb;
  logic [1:0]  err_nxt;

  // The alignment check reads the live inputs when going straight from IDLE
  // to WB, and reads the latched copy when leaving MEM.
  logic        exec_misaligned;
  logic        held_misaligned;

  assign exec_misaligned = exec_reg_pc_w_op && (exec_reg_pc_w_val[1:0] != 2'b00);
  assign held_misaligned = pc_op_q && (pc_tgt_q[1:0] != 2'b00);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    enter_wb  = 1'b0;
    err_nxt   = ERR_NONE;
    case (state)
      ST_IDLE: begin
        if (exec_valid) begin
          if (exec_mem_w_op) begin
            state_nxt = ST_MEM;
          end else begin
            state_nxt = ST_WB;
            enter_wb  = 1'b1;
            err_nxt   = exec_misaligned ? ERR_ALIGN : ERR_NONE;
          end
        end
      end
      ST_MEM: begin
        if (mem_w_ack) begin
          state_nxt = ST_WB;
          enter_wb  = 1'b1;
          err_nxt   = held_misaligned ? ERR_ALIGN : ERR_NONE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          // The store fault takes precedence over a misaligned target.
          state_nxt = ST_WB;
          enter_wb  = 1'b1;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      ST_WB: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state       <= ST_IDLE;
      reg_w_op_q  <= 1'b0;
      reg_w_idx_q <= 5'd0;
      reg_w_val_q <= 32'd0;
      mem_addr_q  <= 32'd0;
      mem_val_q   <= 32'd0;
      pc_op_q     <= 1'b0;
      pc_tgt_q    <= 32'd0;
      pc_q        <= 32'd0;
      tmo_cnt_q   <= 8'd0;
      err_code_q  <= ERR_NONE;
      instret_q   <= 64'd0;
    end else begin
      state <= state_nxt;

      if ((state == ST_IDLE) && exec_valid) begin
        reg_w_op_q  <= exec_reg_w_op;
        reg_w_idx_q <= exec_reg_w_reg_idx;
        reg_w_val_q <= exec_reg_w_reg_val;
        mem_addr_q  <= exec_mem_w_mem_addr;
        mem_val_q   <= exec_mem_w_mem_val;
        pc_op_q     <= exec_reg_pc_w_op;
        pc_tgt_q    <= exec_reg_pc_w_val;
        pc_q        <= reg_pc_val;
      end

      // The counter is held at zero outside MEM, so every MEM entry starts clean.
      if (state != ST_MEM) begin
        tmo_cnt_q <= 8'd0;
      end else if (!mem_w_ack) begin
        tmo_cnt_q <= tmo_cnt_q + 8'd1;
      end

      if (enter_wb) begin
        err_code_q <= err_nxt;
        if (err_nxt == ERR_NONE) begin
          instret_q <= instret_q + 64'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Moore outputs
  // ---------------------------------------------------------------------------
  logic in_wb;
  logic wb_ok;

  assign in_wb = (state == ST_WB);
  assign wb_ok = in_wb && (err_code_q == ERR_NONE);

  assign busy       = (state != ST_IDLE);
  assign mem_w_req  = (state == ST_MEM);
  assign mem_w_addr = mem_w_req ? mem_addr_q : 32'd0;
  assign mem_w_val  = mem_w_req ? mem_val_q  : 32'd0;

  // A write to x0 is dropped without being reported as a fault.
  assign rf_w_en  = wb_ok && reg_w_op_q && (reg_w_idx_q != 5'd0);
  assign rf_w_idx = rf_w_en ? reg_w_idx_q : 5'd0;
  assign rf_w_val = rf_w_en ? reg_w_val_q : 32'd0;

  // Sequential PC wraps modulo 2^32.
  assign pc_w_en  = wb_ok;
  assign pc_w_val = !pc_w_en ? 32'd0 : (pc_op_q ? pc_tgt_q : (pc_q + 32'd4));

  assign commit_done     = in_wb;
  assign commit_err      = in_wb && (err_code_q != ERR_NONE);
  assign commit_err_code = in_wb ? err_code_q : ERR_NONE;
  assign instret         = instret_q;

endmodule
